// File: rtl/bloom_filter_multi.sv
// Multi-hash Bloom filter packet matcher: parses header/payload, tests payload words against a
// programmable bit array and emits one verdict per packet. Counters gated by BLOOM_STATS_EN.
module bloom_filter_multi #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = 8,
  parameter int ARRAY_BITS  = 256,
  parameter int NUM_HASH    = 3,
  parameter int COUNT_WIDTH = 32,
  localparam int IDX_W      = $clog2(ARRAY_BITS),
  localparam int AW         = IDX_W - 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  input  logic                   cfg_wr,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [31:0]            cfg_wdata,
  input  logic                   cfg_clear,
  output logic                   pkt_done,
  output logic                   pkt_match,
  output logic [COUNT_WIDTH-1:0] matches_count,
  output logic [COUNT_WIDTH-1:0] pkts_count
);

  typedef enum logic [1:0] {StStart, StHeader, StPayload} state_e;

  state_e                  state_q, state_d;
  logic                    word_chk, word_eop;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    s1_valid_q, s1_eop_q;
  logic                    s2_eop_q, s2_match_q, sticky_q;
  logic                    done_q, match_q;
  logic                    hit;
  logic [ARRAY_BITS-1:0]   array_q, array_d;

  // Parser: classify the accepted word and advance only when in_wr is high.
  always_comb begin
    state_d  = state_q;
    word_chk = 1'b0;
    word_eop = 1'b0;
    if (in_wr) begin
      unique case (state_q)
        StStart: begin
          if (in_ctrl != '0) state_d = StHeader;
        end
        StHeader: begin
          if (in_ctrl == '0) begin
            state_d  = StPayload;
            word_chk = 1'b1;
          end
        end
        StPayload: begin
          if (in_ctrl == '0) begin
            word_chk = 1'b1;
          end else begin
            word_eop = 1'b1;
            state_d  = StStart;
          end
        end
        default: state_d = StStart;
      endcase
    end
  end

  // Each hash folds rotl(data, 5*i) into IDX_W-bit slices; bit b lands on slice bit b % IDX_W.
  always_comb begin
    logic [IDX_W-1:0] h;
    hit = 1'b1;
    for (int i = 0; i < NUM_HASH; i++) begin
      h = '0;
      for (int b = 0; b < DATA_WIDTH; b++) begin
        h[b % IDX_W] = h[b % IDX_W]
                     ^ s1_data_q[(b + DATA_WIDTH - ((5 * i) % DATA_WIDTH)) % DATA_WIDTH];
      end
      hit = hit & array_q[h];
    end
  end

  always_comb begin
    array_d = array_q;
    if (cfg_clear) begin
      array_d = '0;
    end else if (cfg_wr) begin
      array_d[{cfg_addr, 5'b0} +: 32] = cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StStart;
      array_q    <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_eop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_match_q <= 1'b0;
      sticky_q   <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      array_q    <= array_d;
      s1_data_q  <= in_data;
      s1_valid_q <= word_chk;
      s1_eop_q   <= word_eop;
      // EOP words are never checked, so the verdict is exactly the sticky flag.
      s2_eop_q   <= s1_eop_q;
      s2_match_q <= s1_eop_q & sticky_q;
      sticky_q   <= s1_eop_q ? 1'b0 : (sticky_q | (s1_valid_q & hit));
      done_q     <= s2_eop_q;
      match_q    <= s2_match_q;
    end
  end

  assign pkt_done  = done_q;
  assign pkt_match = match_q;

`ifdef BLOOM_STATS_EN
  logic [COUNT_WIDTH-1:0] pkts_q, matches_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkts_q    <= '0;
      matches_q <= '0;
    end else if (done_q) begin
      if (pkts_q != '1) pkts_q <= pkts_q + COUNT_WIDTH'(1);
      if (match_q && (matches_q != '1)) matches_q <= matches_q + COUNT_WIDTH'(1);
    end
  end

  assign pkts_count    = pkts_q;
  assign matches_count = matches_q;
`else
  assign pkts_count    = '0;
  assign matches_count = '0;
`endif

endmodule

// File: tb/tb_bloom_filter_multi.sv
// Randomized scoreboard bench for bloom_filter_multi with a packet-level reference model.
module tb_bloom_filter_multi;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   in_data = '0;
  logic [7:0]    in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          cfg_clear = 1'b0;
  logic          pkt_done, pkt_match;
  logic [CW-1:0] matches_count, pkts_count;

  bloom_filter_multi #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_clear(cfg_clear),
    .pkt_done(pkt_done), .pkt_match(pkt_match), .matches_count(matches_count),
    .pkts_count(pkts_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [255:0]  model_arr = '0;
  logic          exp_m_q[$];
  int unsigned   exp_c_q[$];
  logic [CW-1:0] exp_pkts = '0, exp_mt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] mhash(input logic [63:0] d, input int i);
    logic [63:0] r;
    logic [7:0]  h;
    int s;
    s = 5 * i;
    r = (s == 0) ? d : ((d << s) | (d >> (64 - s)));
    h = '0;
    for (int k = 0; k < 64; k += 8) h ^= r[k +: 8];
    return h;
  endfunction

  function automatic logic model_hit(input logic [63:0] d);
    logic m;
    m = 1'b1;
    for (int i = 0; i < 3; i++) m &= model_arr[mhash(d, i)];
    return m;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic wr, input logic [7:0] ctrl, input logic [63:0] d);
    @(negedge clk);
    in_wr   = wr;
    in_ctrl = ctrl;
    in_data = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'($urandom), rnd64());
  endtask

  task automatic gapper(input int pct);
    if ($urandom_range(0, 99) < pct) idle($urandom_range(1, 2));
  endtask

  task automatic cfg(input logic wr, input logic [2:0] a, input logic [31:0] w, input logic clr);
    @(negedge clk);
    cfg_wr = wr; cfg_addr = a; cfg_wdata = w; cfg_clear = clr;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_clear = 1'b0;
    if (clr) model_arr = '0;
    else if (wr) model_arr[{a, 5'b0} +: 32] = w;
  endtask

  task automatic send_pkt(input int nh, input logic [63:0] pl[$], input int gap);
    logic m;
    m = 1'b0;
    for (int k = 0; k < nh; k++) begin
      gapper(gap);
      drive(1'b1, 8'($urandom_range(1, 255)), rnd64());
    end
    foreach (pl[k]) begin
      gapper(gap);
      drive(1'b1, 8'h00, pl[k]);
      m |= model_hit(pl[k]);
    end
    gapper(gap);
    drive(1'b1, 8'($urandom_range(1, 255)), rnd64());
    // Accepted on the next edge; verdict visible two edges later.
    exp_m_q.push_back(m);
    exp_c_q.push_back(cyc + 3);
  endtask

  task automatic monitor();
    logic upd, upd_m, m;
    int unsigned c;
    upd = 1'b0; upd_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_pkts = '0; exp_mt = '0; upd = 1'b0;
      end else begin
        if (upd) begin
`ifdef BLOOM_STATS_EN
          if (exp_pkts != CMAX) exp_pkts++;
          if (upd_m && exp_mt != CMAX) exp_mt++;
`endif
          check("pkts_count", 64'(pkts_count), 64'(exp_pkts));
          check("matches_count", 64'(matches_count), 64'(exp_mt));
          upd = 1'b0;
        end
        if (pkt_done) begin
          if (exp_m_q.size() == 0) begin
            check("spurious_pkt_done", 64'(pkt_done), 64'd0);
          end else begin
            m = exp_m_q.pop_front();
            c = exp_c_q.pop_front();
            check("pkt_match", 64'(pkt_match), 64'(m));
            check("pkt_done_cycle", 64'(cyc), 64'(c));
            upd = 1'b1;
            upd_m = m;
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [63:0] pl[$];
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_pkt_match", 64'(pkt_match), 64'd0);
    check("rst_matches", 64'(matches_count), 64'd0);
    check("rst_pkts", 64'(pkts_count), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Only bit 0 set: payload 0 hits, payload 1 misses
    cfg(1'b1, 3'd0, 32'h1, 1'b0);
    pl = '{64'h0};
    send_pkt(1, pl, 0);
    idle(4);
    pl = '{64'h1};
    send_pkt(1, pl, 0);
    idle(4);

    // Back-to-back: hit then miss, sticky must not leak
    pl = '{64'h0};
    send_pkt(1, pl, 0);
    pl = '{64'h1};
    send_pkt(1, pl, 0);
    idle(4);

    // Clear wins over simultaneous write
    cfg(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1);
    pl = '{64'h0};
    send_pkt(1, pl, 0);
    idle(4);

    // Reset after the second payload word of a 5-word packet
    cfg(1'b1, 3'd0, 32'h1, 1'b0);
    drive(1'b1, 8'hFF, rnd64());
    drive(1'b1, 8'h00, 64'h0);
    drive(1'b1, 8'h00, 64'h0);
    @(negedge clk);
    reset_n = 1'b0;
    in_wr = 1'b0;
    model_arr = '0;
    @(negedge clk);
    check("midrst_pkts", 64'(pkts_count), 64'd0);
    check("midrst_matches", 64'(matches_count), 64'd0);
    check("midrst_done", 64'(pkt_done), 64'd0);
    reset_n = 1'b1;
    idle(6);
    cfg(1'b1, 3'd0, 32'h1, 1'b0);
    pl = '{64'h5, 64'h0};
    send_pkt(2, pl, 0);
    idle(4);

    // Random traffic against random arrays
    for (int w = 0; w < 8; w++) cfg(1'b1, 3'(w), $urandom, 1'b0);
    for (int p = 0; p < 40; p++) begin
      if (p % 10 == 9) begin
        idle(4);
        cfg(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b0);
      end
      if ($urandom_range(0, 9) == 0) drive(1'b1, 8'h00, rnd64());
      pl = {};
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        pl.push_back(($urandom_range(0, 3) == 0) ? 64'h0 : rnd64());
      send_pkt($urandom_range(1, 3), pl, $urandom_range(0, 30));
    end
    idle(4);

    // Saturation: 20 matching packets back to back
    cfg(1'b1, 3'd0, 32'h1, 1'b0);
    for (int p = 0; p < 20; p++) begin
      pl = '{64'h0};
      send_pkt(1, pl, 0);
    end
    for (int k = 0; k < 50 && exp_m_q.size() != 0; k++) idle(1);
    check("drain_outstanding", 64'(exp_m_q.size()), 64'd0);
    idle(3);
`ifdef BLOOM_STATS_EN
    check("sat_matches", 64'(matches_count), 64'(CMAX));
    check("sat_pkts", 64'(pkts_count), 64'(CMAX));
`else
    check("sat_matches", 64'(matches_count), 64'd0);
    check("sat_pkts", 64'(pkts_count), 64'd0);
`endif
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
